alu_control_mdu: RTL

//  Next-generation ALU controller for the RV32 datapath. Decodes ALUOp/Funct3/Funct7 into a 5-bit ALU operation
//  and adds the M extension through an iterative multiply/divide unit (MDU) with a valid/ready handshake.

---
 rtl/alu_control_mdu.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_control_mdu.sv
// ALU control decoder with an iterative RV32M multiply/divide unit.
// Operation/is_mdu/stall are combinational; the MDU result path is registered.
`timescale 1ns/1ps
module alu_control_mdu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          ENABLE_M   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            ALUOp,
  input  logic [6:0]            Funct7,
  input  logic [2:0]            Funct3,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  flush,
  output logic [4:0]            Operation,
  output logic                  is_mdu,
  output logic                  in_ready,
  output logic                  stall,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] mdu_result
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned W2 = 2 * DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  localparam logic [4:0] OP_AND  = 5'b00000, OP_OR   = 5'b00001, OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011, OP_SLL  = 5'b00100, OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110, OP_SRA  = 5'b00111, OP_SLT  = 5'b01000;
  localparam logic [4:0] OP_SLTU = 5'b01001, OP_BEQ  = 5'b01010, OP_BNE  = 5'b01011;
  localparam logic [4:0] OP_BLT  = 5'b01100, OP_BGE  = 5'b01101, OP_BLTU = 5'b01110;
  localparam logic [4:0] OP_BGEU = 5'b01111, OP_PASSB = 5'b10000;

  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_n;
  logic [2:0]     f3_q;
  logic           neg_q_r, neg_r_r, spec_q;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   acc_hi, acc_lo, opnd;

  logic           alt, accept, special, last;
  logic           a_signed, b_signed, a_neg, b_neg, div_op, b_zero, ovf;
  logic [W-1:0]   a_mag, b_mag, spec_res;
  logic [W:0]     mul_sum, div_rem, div_diff;
  logic [W-1:0]   step_hi, step_lo;
  logic [W2-1:0]  prod, prod_s;
  logic [W-1:0]   q_s, r_s, fin;

  // Decode ALUOp/Funct3/Funct7 into the ALU operation select
  always_comb begin
    Operation = OP_ADD;
    is_mdu    = 1'b0;
    alt       = (Funct7 == 7'b0100000);
    case (ALUOp)
      2'b00: Operation = OP_ADD;
      2'b01: begin
        case (Funct3)
          3'b001:  Operation = OP_BNE;
          3'b100:  Operation = OP_BLT;
          3'b101:  Operation = OP_BGE;
          3'b110:  Operation = OP_BLTU;
          3'b111:  Operation = OP_BGEU;
          default: Operation = OP_BEQ;
        endcase
      end
      2'b10: begin
        if (ENABLE_M && (Funct7 == 7'b0000001)) begin
          is_mdu    = 1'b1;
          Operation = OP_ADD;
        end else begin
          case (Funct3)
            3'b000:  Operation = alt ? OP_SUB : OP_ADD;
            3'b001:  Operation = OP_SLL;
            3'b010:  Operation = OP_SLT;
            3'b011:  Operation = OP_SLTU;
            3'b100:  Operation = OP_XOR;
            3'b101:  Operation = alt ? OP_SRA : OP_SRL;
            3'b110:  Operation = OP_OR;
            default: Operation = OP_AND;
          endcase
        end
      end
      default: Operation = OP_PASSB;
    endcase
  end

  // Operand magnitudes, signs and one-cycle special cases for a new MDU op
  always_comb begin
    a_signed = (Funct3 != 3'b011) && (Funct3 != 3'b101) && (Funct3 != 3'b111);
    b_signed = a_signed && (Funct3 != 3'b010);
    a_neg    = a_signed & src_a[W-1];
    b_neg    = b_signed & src_b[W-1];
    a_mag    = a_neg ? (~src_a + W'(1)) : src_a;
    b_mag    = b_neg ? (~src_b + W'(1)) : src_b;
    div_op   = Funct3[2];
    b_zero   = (src_b == '0);
    ovf      = b_signed && (src_a == MIN_VAL) && (&src_b);
    special  = div_op && (b_zero || ovf);
    spec_res = b_zero ? (Funct3[1] ? src_a : '1) : (Funct3[1] ? '0 : MIN_VAL);
    accept   = (state == IDLE) && in_valid && is_mdu && !flush;
    last     = (cnt == CW'(W - 1));
  end

  // One shift-add multiply step or one restoring divide step
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_rem  = {acc_hi, acc_lo[W-1]};
    div_diff = div_rem - {1'b0, opnd};
    if (!f3_q[2]) begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], acc_lo[W-1:1]};
    end else if (!div_diff[W]) begin
      step_hi = div_diff[W-1:0];
      step_lo = {acc_lo[W-2:0], 1'b1};
    end else begin
      step_hi = div_rem[W-1:0];
      step_lo = {acc_lo[W-2:0], 1'b0};
    end
  end

  // Sign correction and result selection
  always_comb begin
    prod   = {acc_hi, acc_lo};
    prod_s = neg_q_r ? (~prod + W2'(1)) : prod;
    q_s    = neg_q_r ? (~acc_lo + W'(1)) : acc_lo;
    r_s    = neg_r_r ? (~acc_hi + W'(1)) : acc_hi;
    if (spec_q)
      fin = acc_lo;
    else if (!f3_q[2])
      fin = (f3_q == 3'b000) ? prod_s[W-1:0] : prod_s[W2-1:W];
    else
      fin = f3_q[1] ? r_s : q_s;
  end

  // Handshake-facing combinational outputs
  assign in_ready = (state == IDLE);
  assign stall    = in_valid & is_mdu & ~(out_valid & out_ready);

  // Next-state logic; flush overrides everything
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = special ? DONE : CALC;
      CALC:    if (last) state_n = DONE;
      DONE:    if (out_valid && out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // MDU datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      f3_q       <= '0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      spec_q     <= 1'b0;
      cnt        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      opnd       <= '0;
      out_valid  <= 1'b0;
      mdu_result <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            f3_q    <= Funct3;
            neg_q_r <= a_neg ^ b_neg;
            neg_r_r <= a_neg;
            spec_q  <= special;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= special ? spec_res : (div_op ? a_mag : b_mag);
            opnd    <= div_op ? b_mag : a_mag;
          end
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CW'(1);
        end
        DONE: begin
          if (!out_valid) begin
            mdu_result <= fin;
            out_valid  <= 1'b1;
          end else if (out_ready) begin
            out_valid  <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end
endmodule
